// File: rtl/multi_cycle_ctrl.sv
// ----------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Moore-style control FSM for a multi-cycle MIPS datapath with a shared ALU
// and one unified memory. Sequences fetch / decode / execute / memory /
// writeback for R-type, lw, sw, beq, addi and j. It drives the datapath
// strobes for every cycle and keeps a count of retired instructions.
//
// Ports
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset; all outputs forced to 0 while low
//   op          instr[31:26] from the IR (used in DECODE and MEMADR only)
//   mem_ready   memory completes the current read/write this cycle
//   pc_write    unconditional PC load
//   branch      conditional PC load (datapath ANDs it with ALU zero)
//   pc_src      00 ALU result, 01 ALUOut register, 10 jump target
//   i_or_d      memory address select: 0 PC, 1 ALUOut
//   mem_read    memory read request
//   mem_write   memory write request
//   ir_write    load the instruction register
//   reg_dst     register file write address: 0 rt, 1 rd
//   mem_to_reg  writeback data: 0 ALUOut, 1 MDR
//   reg_write   register file write enable
//   alu_src_a   ALU A operand: 0 PC, 1 register A
//   alu_src_b   ALU B operand: 00 reg B, 01 4, 10 signext imm, 11 signext imm<<2
//   alu_op      00 add, 01 sub, 10 decode funct field
//   state       current state code, for debug
//   instr_done  one-cycle pulse on the final cycle of an instruction
//   illegal_op  one-cycle pulse in DECODE when the opcode is unsupported
//   retired     count of completed legal instructions, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             branch,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] retired_reg;

    // Raw strobes decoded from the state register (plus mem_ready gating).
    logic       pc_write_raw;
    logic       branch_raw;
    logic [1:0] pc_src_raw;
    logic       i_or_d_raw;
    logic       mem_read_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_dst_raw;
    logic       mem_to_reg_raw;
    logic       reg_write_raw;
    logic       alu_src_a_raw;
    logic [1:0] alu_src_b_raw;
    logic [1:0] alu_op_raw;
    logic       instr_done_raw;
    logic       illegal_op_raw;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            // op is held by the IR, so only the store opcode diverts here.
            S_MEMADR: state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Strobe decode (Moore, with mem_ready gating in FETCH and MEMWR)
    // ------------------------------------------------------------------
    always_comb begin
        pc_write_raw   = 1'b0;
        branch_raw     = 1'b0;
        pc_src_raw     = 2'b00;
        i_or_d_raw     = 1'b0;
        mem_read_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        ir_write_raw   = 1'b0;
        reg_dst_raw    = 1'b0;
        mem_to_reg_raw = 1'b0;
        reg_write_raw  = 1'b0;
        alu_src_a_raw  = 1'b0;
        alu_src_b_raw  = 2'b00;
        alu_op_raw     = 2'b00;
        instr_done_raw = 1'b0;
        illegal_op_raw = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read_raw  = 1'b1;
                alu_src_b_raw = 2'b01;
                pc_write_raw  = mem_ready;
                ir_write_raw  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b_raw = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ;
                    default: begin
                        illegal_op_raw = 1'b1;
                        instr_done_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_raw = 1'b1;
                alu_src_b_raw = 2'b10;
            end
            S_MEMRD: begin
                mem_read_raw = 1'b1;
                i_or_d_raw   = 1'b1;
            end
            S_MEMWB: begin
                reg_write_raw  = 1'b1;
                mem_to_reg_raw = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_MEMWR: begin
                mem_write_raw  = 1'b1;
                i_or_d_raw     = 1'b1;
                instr_done_raw = mem_ready;
            end
            S_EXEC: begin
                alu_src_a_raw = 1'b1;
                alu_op_raw    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst_raw    = 1'b1;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_raw  = 1'b1;
                alu_op_raw     = 2'b01;
                pc_src_raw     = 2'b01;
                branch_raw     = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a_raw = 1'b1;
                alu_src_b_raw = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_JUMP: begin
                pc_write_raw   = 1'b1;
                pc_src_raw     = 2'b10;
                instr_done_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // State and retired-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= S_FETCH;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Illegal opcodes close a cycle with instr_done but are not counted.
            if (instr_done_raw && !illegal_op_raw) begin
                retired_reg <= retired_reg + 1'b1;
            end
        end
    end

    // While reset is held the state register already sits in FETCH, whose
    // decode would assert mem_read; the outputs are masked so the datapath
    // sees every strobe low for the whole reset interval.
    assign pc_write   = resetn & pc_write_raw;
    assign branch     = resetn & branch_raw;
    assign pc_src     = {2{resetn}} & pc_src_raw;
    assign i_or_d     = resetn & i_or_d_raw;
    assign mem_read   = resetn & mem_read_raw;
    assign mem_write  = resetn & mem_write_raw;
    assign ir_write   = resetn & ir_write_raw;
    assign reg_dst    = resetn & reg_dst_raw;
    assign mem_to_reg = resetn & mem_to_reg_raw;
    assign reg_write  = resetn & reg_write_raw;
    assign alu_src_a  = resetn & alu_src_a_raw;
    assign alu_src_b  = {2{resetn}} & alu_src_b_raw;
    assign alu_op     = {2{resetn}} & alu_op_raw;
    assign instr_done = resetn & instr_done_raw;
    assign illegal_op = resetn & illegal_op_raw;
    assign state      = state_reg;
    assign retired    = retired_reg;

endmodule
